// File: rtl/inj_arb_pkg.sv
// Shared types and helpers for the NoC injection-port arbiter.
// Optional stall watchdog is enabled by the INJ_ARB_TIMEOUT_EN macro in inj_port_arbiter.
package inj_arb_pkg;

  typedef enum logic {IDLE, GRANT} inj_arb_state_t;

  localparam int FLIT_CNT_W = 32;

  // Saturating increment so a very long stream never wraps the flit counter.
  function automatic logic [FLIT_CNT_W-1:0] sat_inc(input logic [FLIT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/inj_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from N_REQ-1 back to 0.
module inj_rr_picker #(
  parameter int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_req;

  // Candidate at offset gi from the pointer, i.e. the rotated request vector.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = IDX_W'((int'(ptr) + gi) % N_REQ);
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  // Scan from the farthest offset down so the nearest requester overrides.
  always_comb begin
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        idx = cand_idx[k];
      end
    end
  end

  assign valid = |req;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
    assign gnt[gi] = valid && (idx == IDX_W'(gi));
  end

endmodule

// File: rtl/inj_port_arbiter.sv
// Lock-based arbiter sharing one NoC injection port between N_REQ injectors.
// Define INJ_ARB_TIMEOUT_EN to add a sticky stall watchdog on timeout_o.
module inj_port_arbiter
  import inj_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int FLIT_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [N_REQ-1:0]                  tx_i,
  input  logic [N_REQ-1:0][FLIT_SIZE-1:0]   data_i,
  output logic [N_REQ-1:0]                  credit_o,
  output logic                              tx_o,
  output logic [FLIT_SIZE-1:0]              data_o,
  input  logic                              credit_i,
  output logic [N_REQ-1:0]                  grant_o,
  output logic                              busy_o,
  output logic [FLIT_CNT_W-1:0]             flit_cnt_o,
  output logic                              timeout_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  inj_arb_state_t          state_reg, state_next;
  logic [N_REQ-1:0]        grant_reg, grant_next;
  logic [IDX_W-1:0]        grant_idx_reg, grant_idx_next;
  logic [IDX_W-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [FLIT_CNT_W-1:0]   flit_cnt_reg, flit_cnt_next;

  logic                    pick_valid;
  logic [N_REQ-1:0]        pick_gnt;
  logic [IDX_W-1:0]        pick_idx;
  logic                    busy;

  inj_rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req   (tx_i),
    .ptr   (rr_ptr_reg),
    .valid (pick_valid),
    .gnt   (pick_gnt),
    .idx   (pick_idx)
  );

  assign busy = (state_reg == GRANT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
      flit_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      grant_idx_reg <= grant_idx_next;
      rr_ptr_reg    <= rr_ptr_next;
      flit_cnt_reg  <= flit_cnt_next;
    end
  end

  // A release always passes through IDLE, so a waiting requester sees one bubble.
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    grant_idx_next = grant_idx_reg;
    rr_ptr_next    = rr_ptr_reg;
    flit_cnt_next  = flit_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next     = GRANT;
          grant_next     = pick_gnt;
          grant_idx_next = pick_idx;
          flit_cnt_next  = '0;
        end
      end
      GRANT: begin
        if (!tx_i[grant_idx_reg]) begin
          state_next  = IDLE;
          grant_next  = '0;
          rr_ptr_next = (grant_idx_reg == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_reg + 1'b1;
        end else if (credit_i) begin
          flit_cnt_next = sat_inc(flit_cnt_reg);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Port mux is combinational from the grant register: zero added latency.
  assign tx_o       = busy && tx_i[grant_idx_reg];
  assign data_o     = busy ? data_i[grant_idx_reg] : '0;
  assign grant_o    = grant_reg;
  assign busy_o     = busy;
  assign flit_cnt_o = flit_cnt_reg;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_credit
    assign credit_o[gi] = grant_reg[gi] && credit_i;
  end

`ifdef INJ_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic               timeout_reg, timeout_next;

  always_comb begin
    stall_cnt_next = '0;
    if (tx_o && !credit_i) begin
      stall_cnt_next = (stall_cnt_reg == STALL_W'(TIMEOUT_CYCLES)) ?
                       stall_cnt_reg : stall_cnt_reg + 1'b1;
    end
    timeout_next = timeout_reg || (stall_cnt_next == STALL_W'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign timeout_o = timeout_reg;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_inj_port_arbiter.sv
// Table-driven, scoreboard-checked bench for inj_port_arbiter (N_REQ=2).
module tb_inj_port_arbiter;

  localparam int N_REQ = 2;
  localparam int FW    = 32;
  localparam int TO    = 8;
`ifdef INJ_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                         clk_i;
  logic                         rst_i;
  logic [N_REQ-1:0]             tx_i;
  logic [N_REQ-1:0][FW-1:0]     data_i;
  logic [N_REQ-1:0]             credit_o;
  logic                         tx_o;
  logic [FW-1:0]                data_o;
  logic                         credit_i;
  logic [N_REQ-1:0]             grant_o;
  logic                         busy_o;
  logic [31:0]                  flit_cnt_o;
  logic                         timeout_o;

  inj_port_arbiter #(
    .N_REQ          (N_REQ),
    .FLIT_SIZE      (FW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tx_i       (tx_i),
    .data_i     (data_i),
    .credit_o   (credit_o),
    .tx_o       (tx_o),
    .data_o     (data_o),
    .credit_i   (credit_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .flit_cnt_o (flit_cnt_o),
    .timeout_o  (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [1:0]  tx;
    logic        cr;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        e_tx;
    logic [31:0] e_data;
    logic [1:0]  e_cred;
    logic [1:0]  e_gnt;
    logic        e_busy;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic r, input logic [1:0] t, input logic c,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic etx, input logic [31:0] ed, input logic [1:0] ecr,
                              input logic [1:0] eg, input logic [31:0] ecnt);
    vec_t v;
    v.rst = r; v.tx = t; v.cr = c; v.d0 = a; v.d1 = b;
    v.e_tx = etx; v.e_data = ed; v.e_cred = ecr; v.e_gnt = eg;
    v.e_busy = |eg; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [1:0] t, input logic c,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk_i);
    #1;
    rst_i     = r;
    tx_i      = t;
    credit_i  = c;
    data_i[0] = a;
    data_i[1] = b;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end else begin
      $display("%s ok (%0h)", name, act);
    end
  endtask

  initial begin
    vec_t e;
    rst_i = 1'b1; tx_i = '0; credit_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk_i);

    // reset state
    vecs.push_back(mk(1, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    // req0 streams 5 flits with constant credit
    vecs.push_back(mk(0, 2'b01, 1, 32'hA0, 0, 0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'hA0, 0, 1, 32'hA0, 2'b01, 2'b01, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'hA1, 0, 1, 32'hA1, 2'b01, 2'b01, 1));
    vecs.push_back(mk(0, 2'b01, 1, 32'hA2, 0, 1, 32'hA2, 2'b01, 2'b01, 2));
    vecs.push_back(mk(0, 2'b01, 1, 32'hA3, 0, 1, 32'hA3, 2'b01, 2'b01, 3));
    vecs.push_back(mk(0, 2'b01, 1, 32'hA4, 0, 1, 32'hA4, 2'b01, 2'b01, 4));
    vecs.push_back(mk(0, 2'b00, 1, 0, 0, 0, 0, 2'b01, 2'b01, 5));
    vecs.push_back(mk(0, 2'b00, 1, 32'hDEAD, 32'hBEEF, 0, 0, 2'b00, 2'b00, 5));
    // reset, then both request together
    vecs.push_back(mk(1, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00, 5));
    vecs.push_back(mk(0, 2'b11, 1, 32'hB0, 32'hC0, 0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 2'b11, 1, 32'hB0, 32'hC0, 1, 32'hB0, 2'b01, 2'b01, 0));
    vecs.push_back(mk(0, 2'b10, 1, 0, 32'hC0, 0, 0, 2'b01, 2'b01, 1));
    vecs.push_back(mk(0, 2'b10, 1, 0, 32'hC0, 0, 0, 2'b00, 2'b00, 1));
    vecs.push_back(mk(0, 2'b10, 1, 0, 32'hC0, 1, 32'hC0, 2'b10, 2'b10, 0));
    vecs.push_back(mk(0, 2'b00, 1, 0, 0, 0, 0, 2'b10, 2'b10, 1));
    vecs.push_back(mk(0, 2'b11, 1, 32'hB1, 32'hC1, 0, 0, 2'b00, 2'b00, 1));
    vecs.push_back(mk(0, 2'b00, 1, 0, 0, 0, 0, 2'b01, 2'b01, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h5555, 32'h6666, 0, 0, 2'b00, 2'b00, 0));
    // credit 1,0 pattern, flits A..D held through credit-low cycles (pick wraps 1->0)
    vecs.push_back(mk(0, 2'b01, 1, 32'hD0A, 0, 0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'hA, 0, 1, 32'hA, 2'b01, 2'b01, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'hB, 0, 1, 32'hB, 2'b00, 2'b01, 1));
    vecs.push_back(mk(0, 2'b01, 1, 32'hB, 0, 1, 32'hB, 2'b01, 2'b01, 1));
    vecs.push_back(mk(0, 2'b01, 0, 32'hC, 0, 1, 32'hC, 2'b00, 2'b01, 2));
    vecs.push_back(mk(0, 2'b01, 1, 32'hC, 0, 1, 32'hC, 2'b01, 2'b01, 2));
    vecs.push_back(mk(0, 2'b01, 0, 32'hD, 0, 1, 32'hD, 2'b00, 2'b01, 3));
    vecs.push_back(mk(0, 2'b01, 1, 32'hD, 0, 1, 32'hD, 2'b01, 2'b01, 3));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01, 4));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4));
    // req1 rises while req0 holds the port
    vecs.push_back(mk(0, 2'b01, 1, 32'hE0, 0, 0, 0, 2'b00, 2'b00, 4));
    vecs.push_back(mk(0, 2'b01, 1, 32'hE0, 0, 1, 32'hE0, 2'b01, 2'b01, 0));
    vecs.push_back(mk(0, 2'b11, 1, 32'hE1, 32'hF0, 1, 32'hE1, 2'b01, 2'b01, 1));
    vecs.push_back(mk(0, 2'b11, 1, 32'hE2, 32'hF0, 1, 32'hE2, 2'b01, 2'b01, 2));
    vecs.push_back(mk(0, 2'b10, 1, 0, 32'hF0, 0, 0, 2'b01, 2'b01, 3));
    vecs.push_back(mk(0, 2'b10, 1, 0, 32'hF0, 0, 0, 2'b00, 2'b00, 3));
    vecs.push_back(mk(0, 2'b10, 1, 0, 32'hF0, 1, 32'hF0, 2'b10, 2'b10, 0));
    vecs.push_back(mk(0, 2'b00, 1, 0, 0, 0, 0, 2'b10, 2'b10, 1));
    vecs.push_back(mk(0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1));
    // move rr_ptr to 1, then reset mid-grant after 3 flits
    vecs.push_back(mk(0, 2'b01, 1, 32'h60, 0, 0, 0, 2'b00, 2'b00, 1));
    vecs.push_back(mk(0, 2'b00, 1, 0, 0, 0, 0, 2'b01, 2'b01, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h60, 0, 0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h60, 0, 1, 32'h60, 2'b01, 2'b01, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h61, 0, 1, 32'h61, 2'b01, 2'b01, 1));
    vecs.push_back(mk(0, 2'b01, 1, 32'h62, 0, 1, 32'h62, 2'b01, 2'b01, 2));
    vecs.push_back(mk(1, 2'b01, 1, 32'h63, 0, 1, 32'h63, 2'b01, 2'b01, 3));
    vecs.push_back(mk(0, 2'b11, 1, 32'h63, 32'h70, 0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 2'b11, 1, 32'h63, 32'h70, 1, 32'h63, 2'b01, 2'b01, 0));
    vecs.push_back(mk(0, 2'b00, 1, 0, 0, 0, 0, 2'b01, 2'b01, 1));
    vecs.push_back(mk(0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].tx, vecs[i].cr, vecs[i].d0, vecs[i].d1);
      exp_q.push_back(vecs[i]);
      @(negedge clk_i);
      e = exp_q.pop_front();
      n_vec++;
      if ({tx_o, data_o, credit_o, grant_o, busy_o, flit_cnt_o, timeout_o} !==
          {e.e_tx, e.e_data, e.e_cred, e.e_gnt, e.e_busy, e.e_cnt, 1'b0}) begin
        n_miss++;
        $display("FAIL vec%0d: got tx=%0b data=%h cred=%b gnt=%b busy=%0b cnt=%0d to=%0b, want tx=%0b data=%h cred=%b gnt=%b busy=%0b cnt=%0d to=0",
                 i, tx_o, data_o, credit_o, grant_o, busy_o, flit_cnt_o, timeout_o,
                 e.e_tx, e.e_data, e.e_cred, e.e_gnt, e.e_busy, e.e_cnt);
      end else begin
        $display("vec%0d ok: tx=%0b data=%h cred=%b gnt=%b cnt=%0d",
                 i, tx_o, data_o, credit_o, grant_o, flit_cnt_o);
      end
    end

    // stall watchdog: req0 granted with credit held low
    drive(0, 2'b01, 0, 32'h77, 0);
    @(negedge clk_i);
    chk("stall_idle_gnt", 32'(grant_o), 32'h0);
    for (int k = 1; k <= TO + 1; k++) begin
      drive(0, 2'b01, 0, 32'h77, 0);
      @(negedge clk_i);
      chk($sformatf("stall%0d_port", k), {29'd0, tx_o, credit_o}, {29'd0, 1'b1, 2'b00});
      chk($sformatf("stall%0d_timeout", k), 32'(timeout_o), 32'(TO_EN && (k == TO + 1)));
    end
    drive(0, 2'b00, 0, 0, 0);
    @(negedge clk_i);
    chk("release_timeout", 32'(timeout_o), 32'(TO_EN));
    drive(0, 2'b00, 1, 0, 0);
    @(negedge clk_i);
    chk("sticky_timeout", 32'(timeout_o), 32'(TO_EN));
    chk("sticky_gnt", 32'(grant_o), 32'h0);
    drive(1, 2'b00, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 0);
    @(negedge clk_i);
    chk("reset_timeout", 32'(timeout_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
